// File: rtl/i2s_stream_core.sv
// i2s_stream_core: single-clock I2S transceiver. Generates SCLK/WS from mclk,
// deserialises stereo frames from sd_rx into a frame FIFO, applies a channel
// mode at each tx frame load and serialises the result on sd_tx.
// Optional build macro I2S_GAIN_EN adds a gain_shift input (arithmetic right
// shift of tx samples at load); without it samples go out unscaled.
module i2s_stream_core #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int SCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
`ifdef I2S_GAIN_EN
    input  logic [3:0]                    gain_shift,
`endif
    input  logic                          sd_rx,
    output logic                          sd_tx,
    output logic                          sclk,
    output logic                          ws,
    output logic signed [SAMPLE_W-1:0]    rx_data_l,
    output logic signed [SAMPLE_W-1:0]    rx_data_r,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(FRAME);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME - 2);
    localparam logic [BIT_W-1:0] BIT_WS   = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_R0   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] BIT_LEND = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] BIT_REND = BIT_W'(SLOT_W + SAMPLE_W);
    localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(SLOT_W + SAMPLE_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Channel mode: mono is the floor average over a SAMPLE_W+1-bit signed sum.
    function automatic logic [2*SAMPLE_W-1:0] apply_mode(input logic [1:0] m,
                                                         input sample_t l, input sample_t r);
        logic signed [SAMPLE_W:0] sum;
        sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
        case (m)
            2'b00:   apply_mode = {l, r};
            2'b01:   apply_mode = {r, l};
            2'b10:   apply_mode = '0;
            default: apply_mode = {sum[SAMPLE_W:1], sum[SAMPLE_W:1]};
        endcase
    endfunction

`ifdef I2S_GAIN_EN
    function automatic sample_t apply_gain(input sample_t s, input logic [3:0] sh);
        apply_gain = s >>> sh;
    endfunction
`endif

    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d, bit_next;
    logic                    armed_q, armed_d;
    sample_t                 rx_l_sh_q, rx_l_sh_d, rx_r_sh_q, rx_r_sh_d;
    sample_t                 rx_data_l_q, rx_data_l_d, rx_data_r_q, rx_data_r_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ovf_q, ovf_d, und_q, und_d;
    logic [2*SAMPLE_W-1:0]   tx_sh_q, tx_sh_d;
    logic                    sd_tx_q, sd_tx_d;
    logic [2*SAMPLE_W-1:0]   mem_q [FIFO_DEPTH];
    logic [2*SAMPLE_W-1:0]   wr_data, pop_data, moded;
    sample_t                 tx_l, tx_r;
    logic                    rise_ev, div_last, rx_done, full, empty, wr_en, pop_ok;
    logic                    tx_load;

    assign rise_ev  = (div_q == DIV_HALF);
    assign div_last = (div_q == DIV_LAST);
    assign bit_next = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
    assign tx_load  = div_last && (bit_q == BIT_LOAD);
    assign rx_done  = rise_ev && armed_q && (bit_q == BIT_DONE);
    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign wr_en    = rx_done && (!full || tx_load);
    assign pop_ok   = tx_load && !empty;

    // Tx frame source: FIFO head (zero on underrun), then mode and optional gain.
    always_comb begin
        pop_data = empty ? '0 : mem_q[rd_ptr_q];
        moded    = apply_mode(mode, sample_t'(pop_data[2*SAMPLE_W-1:SAMPLE_W]),
                              sample_t'(pop_data[SAMPLE_W-1:0]));
`ifdef I2S_GAIN_EN
        tx_l = apply_gain(sample_t'(moded[2*SAMPLE_W-1:SAMPLE_W]), gain_shift);
        tx_r = apply_gain(sample_t'(moded[SAMPLE_W-1:0]), gain_shift);
`else
        tx_l = sample_t'(moded[2*SAMPLE_W-1:SAMPLE_W]);
        tx_r = sample_t'(moded[SAMPLE_W-1:0]);
`endif
    end

    // Next-state logic for divider, framing, rx capture, FIFO control and tx shifter.
    always_comb begin
        div_d       = div_last ? '0 : div_q + DIV_W'(1);
        bit_d       = bit_q;
        armed_d     = armed_q;
        rx_l_sh_d   = rx_l_sh_q;
        rx_r_sh_d   = rx_r_sh_q;
        rx_data_l_d = rx_data_l_q;
        rx_data_r_d = rx_data_r_q;
        rx_valid_d  = rx_done;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        und_d       = und_q;
        tx_sh_d     = tx_sh_q;
        sd_tx_d     = sd_tx_q;

        // Receiver aligns on the first frame boundary after reset, as an
        // I2S receiver does on a WS edge; the partial frame 0 is not captured.
        if (div_last) begin
            bit_d = bit_next;
            if (bit_q == BIT_LAST) armed_d = 1'b1;
        end

        if (rise_ev) begin
            if (bit_q < BIT_LEND)
                rx_l_sh_d = sample_t'({rx_l_sh_q, sd_rx});
            else if (bit_q >= BIT_R0 && bit_q < BIT_REND)
                rx_r_sh_d = sample_t'({rx_r_sh_q, sd_rx});
        end
        wr_data = {rx_l_sh_q, rx_r_sh_d};

        if (rx_done) begin
            rx_data_l_d = rx_l_sh_q;
            rx_data_r_d = rx_r_sh_d;
            if (!wr_en) ovf_d = 1'b1;
        end

        if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (div_last) begin
            if (bit_next < BIT_LEND || (bit_next >= BIT_R0 && bit_next < BIT_REND)) begin
                sd_tx_d = tx_sh_q[2*SAMPLE_W-1];
                tx_sh_d = tx_sh_q << 1;
            end else begin
                sd_tx_d = 1'b0;
            end
        end
        if (tx_load) begin
            tx_sh_d = {tx_l, tx_r};
            if (empty) und_d = 1'b1;
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            bit_q       <= '0;
            armed_q     <= 1'b0;
            rx_l_sh_q   <= '0;
            rx_r_sh_q   <= '0;
            rx_data_l_q <= '0;
            rx_data_r_q <= '0;
            rx_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            und_q       <= 1'b0;
            tx_sh_q     <= '0;
            sd_tx_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            armed_q     <= armed_d;
            rx_l_sh_q   <= rx_l_sh_d;
            rx_r_sh_q   <= rx_r_sh_d;
            rx_data_l_q <= rx_data_l_d;
            rx_data_r_q <= rx_data_r_d;
            rx_valid_q  <= rx_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            und_q       <= und_d;
            tx_sh_q     <= tx_sh_d;
            sd_tx_q     <= sd_tx_d;
        end
    end

    // Frame storage; contents are don't-care until written.
    always_ff @(posedge mclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign sclk       = (div_q >= DIV_HALF);
    assign ws         = (bit_q >= BIT_WS) && (bit_q <= BIT_LOAD);
    assign sd_tx      = sd_tx_q;
    assign rx_data_l  = rx_data_l_q;
    assign rx_data_r  = rx_data_r_q;
    assign rx_valid   = rx_valid_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign underrun   = und_q;

endmodule
